// File: rtl/ddr_clkmux_nto1_diff_ctrl.sv
// N-to-1 differential clock mux with a glitch-free gate-off/settle/apply/settle select sequencer.
// Optional DDR_CLKMUX_SWCNT_EN adds a saturating count of completed select changes.
module ddr_clkmux_nto1_diff_ctrl #(
    parameter int unsigned NUM_IN    = 3,
    parameter int unsigned SEL_W     = $clog2(NUM_IN + 1),
    parameter int unsigned OFF_CYC   = 4,
    parameter int unsigned ON_CYC    = 4,
    parameter int unsigned RESET_SEL = 0
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [NUM_IN-1:0] i_clk_c,
    input  logic [NUM_IN-1:0] i_clk_t,
    input  logic              i_req,
    input  logic [SEL_W-1:0]  i_sel,
`ifdef DDR_CLKMUX_SWCNT_EN
    input  logic              i_sw_cnt_clr,
    output logic [7:0]        o_sw_cnt,
`endif
    output logic              o_ack,
    output logic              o_busy,
    output logic              o_err,
    output logic [SEL_W-1:0]  o_cur_sel,
    output logic              o_c,
    output logic              o_t
);

    localparam logic [SEL_W-1:0] MAX_SEL     = SEL_W'(NUM_IN);
    localparam logic [SEL_W-1:0] RESET_SEL_V = SEL_W'(RESET_SEL);
    localparam logic [7:0]       OFF_LOAD    = 8'(OFF_CYC - 1);
    localparam logic [7:0]       ON_LOAD     = 8'(ON_CYC - 1);

    typedef enum logic [2:0] {
        IDLE, GATE, WAIT_OFF, APPLY, WAIT_ON, DONE
    } state_t;

    state_t           state_q, state_d;
    logic [SEL_W-1:0] cur_sel_q, cur_sel_d;
    logic [SEL_W-1:0] tgt_q, tgt_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             ack_q, ack_d;
    logic             oerr_q, oerr_d;
    logic             busy_q, busy_d;
    logic             t_mux, c_mux;

    always_comb begin
        t_mux = 1'b0;
        c_mux = 1'b1;
        for (int unsigned k = 0; k < NUM_IN; k++) begin
            if (cur_sel_q == SEL_W'(k + 1)) begin
                t_mux = i_clk_t[k];
                c_mux = i_clk_c[k];
            end
        end
    end

    // The GATE and APPLY cycles each count toward their window, so the wait
    // states run one cycle short of OFF_CYC/ON_CYC and are skipped when it is 1.
    always_comb begin
        state_d   = state_q;
        cur_sel_d = cur_sel_q;
        tgt_d     = tgt_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        ack_d     = 1'b0;
        oerr_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (i_req) begin
                    tgt_d = i_sel;
                    if (i_sel > MAX_SEL) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else if (i_sel == cur_sel_q) begin
                        state_d = DONE;
                    end else begin
                        state_d = GATE;
                    end
                end
            end
            GATE: begin
                cur_sel_d = '0;
                cnt_d     = OFF_LOAD;
                if (OFF_CYC == 1) state_d = (tgt_q == '0) ? DONE : APPLY;
                else              state_d = WAIT_OFF;
            end
            WAIT_OFF: begin
                cnt_d = cnt_q - 8'd1;
                if (cnt_q == 8'd1) state_d = (tgt_q == '0) ? DONE : APPLY;
            end
            APPLY: begin
                cur_sel_d = tgt_q;
                cnt_d     = ON_LOAD;
                if (ON_CYC == 1) state_d = DONE;
                else             state_d = WAIT_ON;
            end
            WAIT_ON: begin
                cnt_d = cnt_q - 8'd1;
                if (cnt_q == 8'd1) state_d = DONE;
            end
            DONE: begin
                ack_d   = 1'b1;
                oerr_d  = err_q;
                err_d   = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            cur_sel_q <= RESET_SEL_V;
            tgt_q     <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            ack_q     <= 1'b0;
            oerr_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cur_sel_q <= cur_sel_d;
            tgt_q     <= tgt_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            ack_q     <= ack_d;
            oerr_q    <= oerr_d;
            busy_q    <= busy_d;
        end
    end

`ifdef DDR_CLKMUX_SWCNT_EN
    logic       sw_q, sw_d;
    logic [7:0] sw_cnt_q, sw_cnt_d;

    always_comb begin
        sw_d = sw_q;
        if (state_q == IDLE && i_req) sw_d = (i_sel <= MAX_SEL) && (i_sel != cur_sel_q);
        sw_cnt_d = sw_cnt_q;
        if (i_sw_cnt_clr)                                        sw_cnt_d = '0;
        else if (state_q == DONE && sw_q && sw_cnt_q != 8'hFF) sw_cnt_d = sw_cnt_q + 8'd1;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sw_q     <= 1'b0;
            sw_cnt_q <= '0;
        end else begin
            sw_q     <= sw_d;
            sw_cnt_q <= sw_cnt_d;
        end
    end

    assign o_sw_cnt = sw_cnt_q;
`endif

    assign o_ack     = ack_q;
    assign o_busy    = busy_q;
    assign o_err     = oerr_q;
    assign o_cur_sel = cur_sel_q;
    assign o_t       = t_mux;
    assign o_c       = c_mux;

endmodule

// File: tb/tb_ddr_clkmux_nto1_diff_ctrl.sv
// Directed + random bench for ddr_clkmux_nto1_diff_ctrl against a trace-level model.
module tb_ddr_clkmux_nto1_diff_ctrl;

    localparam int NUM_IN    = 3;
    localparam int SEL_W     = 3;
    localparam int OFF_CYC   = 4;
    localparam int ON_CYC    = 4;
    localparam int RESET_SEL = 0;

    logic              i_clk = 1'b0;
    logic              i_rst_n;
    logic [NUM_IN-1:0] i_clk_c, i_clk_t;
    logic              i_req;
    logic [SEL_W-1:0]  i_sel;
    logic              o_ack, o_busy, o_err, o_c, o_t;
    logic [SEL_W-1:0]  o_cur_sel;
`ifdef DDR_CLKMUX_SWCNT_EN
    logic              i_sw_cnt_clr;
    logic [7:0]        o_sw_cnt;
`endif

    int n_checks = 0;
    int n_err    = 0;
    int model_cur = RESET_SEL;
    int model_sw  = 0;

    ddr_clkmux_nto1_diff_ctrl #(
        .NUM_IN(NUM_IN), .SEL_W(SEL_W), .OFF_CYC(OFF_CYC), .ON_CYC(ON_CYC), .RESET_SEL(RESET_SEL)
    ) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_clk_c(i_clk_c), .i_clk_t(i_clk_t),
        .i_req(i_req), .i_sel(i_sel),
`ifdef DDR_CLKMUX_SWCNT_EN
        .i_sw_cnt_clr(i_sw_cnt_clr), .o_sw_cnt(o_sw_cnt),
`endif
        .o_ack(o_ack), .o_busy(o_busy), .o_err(o_err), .o_cur_sel(o_cur_sel),
        .o_c(o_c), .o_t(o_t)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Randomise the source clocks, then compare the mux against the model selection.
    task automatic check_mux(input string tag, input int sel);
        logic et, ec;
        i_clk_t = NUM_IN'($urandom_range(0, 7));
        i_clk_c = NUM_IN'($urandom_range(0, 7));
        #1;
        et = 1'b0;
        ec = 1'b1;
        if (sel >= 1 && sel <= NUM_IN) begin
            et = i_clk_t[sel-1];
            ec = i_clk_c[sel-1];
        end
        check({tag, "_t"}, o_t, et);
        check({tag, "_c"}, o_c, ec);
    endtask

    task automatic run_req(input int sel, input int inj_n, input int inj_sel, input int rst_at);
        int  old_cur, lat, exp_cur;
        bit  illegal, same;
        old_cur = model_cur;
        illegal = (sel > NUM_IN);
        same    = !illegal && (sel == old_cur);
        if (illegal || same) lat = 2;
        else if (sel == 0)   lat = 2 + OFF_CYC;
        else                 lat = 2 + OFF_CYC + ON_CYC;
        exp_cur = old_cur;
        i_req = 1'b1;
        i_sel = SEL_W'(sel);
        for (int n = 1; n <= lat + 2; n++) begin
            @(posedge i_clk);
            #1;
            i_req = 1'b0;
            if (n == inj_n) begin
                i_req = 1'b1;
                i_sel = SEL_W'(inj_sel);
            end
            if (n == rst_at) begin
                i_rst_n = 1'b0;
                #1;
                check("rst_mid_cur", o_cur_sel, RESET_SEL);
                check("rst_mid_busy", o_busy, 0);
                check("rst_mid_ack", o_ack, 0);
                check_mux("rst_mid_mux", RESET_SEL);
                model_cur = RESET_SEL;
                model_sw  = 0;
                @(posedge i_clk);
                #1;
                i_rst_n = 1'b1;
                for (int m = 0; m < lat; m++) begin
                    @(posedge i_clk);
                    #2;
                    check("rst_post_ack", o_ack, 0);
                    check("rst_post_busy", o_busy, 0);
                    check("rst_post_cur", o_cur_sel, RESET_SEL);
                end
                return;
            end
            if (illegal || same || n == 1)       exp_cur = old_cur;
            else if (sel == 0 || n < 2 + OFF_CYC) exp_cur = 0;
            else                                  exp_cur = sel;
            check_mux("mux", exp_cur);
            check("cur_sel", o_cur_sel, exp_cur);
            check("busy", o_busy, (n < lat));
            check("ack", o_ack, (n == lat));
            check("err", o_err, (n == lat) && illegal);
        end
        model_cur = exp_cur;
        if (!illegal && !same && model_sw < 255) model_sw++;
    endtask

    initial begin
        i_rst_n = 1'b0;
        i_req   = 1'b0;
        i_sel   = '0;
        i_clk_t = '0;
        i_clk_c = '0;
`ifdef DDR_CLKMUX_SWCNT_EN
        i_sw_cnt_clr = 1'b0;
`endif
        repeat (3) @(posedge i_clk);
        #1;
        check("rst_cur", o_cur_sel, RESET_SEL);
        check("rst_busy", o_busy, 0);
        check("rst_ack", o_ack, 0);
        check("rst_err", o_err, 0);
        i_rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge i_clk);
            #1;
            check_mux("gated_mux", 0);
            check("idle_busy", o_busy, 0);
        end

        run_req(1, -1, 0, -1);
        run_req(3, -1, 0, -1);
        run_req(2, -1, 0, -1);
        run_req(2, -1, 0, -1);
        run_req(5, -1, 0, -1);
        run_req(7, -1, 0, -1);
        run_req(1, -1, 0, -1);
        run_req(2, 3, 1, -1);
        run_req(0, -1, 0, -1);
        run_req(0, -1, 0, -1);
        for (int i = 0; i < 20; i++) run_req(int'($urandom_range(0, 7)), -1, 0, -1);
        run_req(1, -1, 0, -1);
        run_req(2, -1, 0, 2 + OFF_CYC + 1);
        run_req(3, -1, 0, -1);

`ifdef DDR_CLKMUX_SWCNT_EN
        check("swcnt_model", o_sw_cnt, model_sw);
        i_sw_cnt_clr = 1'b1;
        @(posedge i_clk);
        #1;
        i_sw_cnt_clr = 1'b0;
        model_sw = 0;
        check("swcnt_clr", o_sw_cnt, 0);
        for (int i = 0; i < 256; i++) run_req((i % 2 == 0) ? 1 : 2, -1, 0, -1);
        check("swcnt_sat", o_sw_cnt, model_sw);
        check("swcnt_sat255", o_sw_cnt, 255);
        i_sw_cnt_clr = 1'b1;
        @(posedge i_clk);
        #1;
        i_sw_cnt_clr = 1'b0;
        check("swcnt_clr2", o_sw_cnt, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
